// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional debug read port is enabled with MEM_DEBUG_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // True for a misaligned byte address or one beyond the word array.
    function automatic logic addr_bad(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the wait states of one memory access.
module mem_wait_counter
    import mem_resp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array with programmable wait states and error flagging.
// Define MEM_DEBUG_EN to add the non-intrusive debug_addr/debug_data read port.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err
`ifdef MEM_DEBUG_EN
    ,
    input  logic [6:0]  debug_addr,
    output logic [31:0] debug_data
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_array [DEPTH];

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        both_q, both_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        mem_err_q, mem_err_d;

    logic             req;
    logic             from_idle;
    logic [31:0]      act_addr;
    logic             act_write;
    logic             act_both;
    logic             act_bad;
    logic [31:0]      act_word;
    logic             enter_done;
    logic             wr_en;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_zero;

    // From IDLE the live request completes the access when LATENCY is 0; otherwise the captured one does.
    assign req       = mem_ren | mem_wen;
    assign from_idle = (state_q == IDLE);
    assign act_addr  = from_idle ? mem_addr : addr_q;
    assign act_write = from_idle ? mem_wen : write_q;
    assign act_both  = from_idle ? (mem_ren & mem_wen) : both_q;
    assign act_bad   = addr_bad(act_addr, ADDR_WIDTH);
    assign act_word  = mem_array[act_addr[ADDR_WIDTH+1:2]];

    mem_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (CNT_W'(LATENCY)),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        both_d     = both_q;
        enter_done = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_dout;
                    write_d = mem_wen;
                    both_d  = mem_ren & mem_wen;
                    if (LATENCY == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d  = WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if ((cnt_count == CNT_W'(1)) || cnt_zero) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data and the error flag are registered so both are valid throughout DONE.
    always_comb begin
        mem_din_d = mem_din_q;
        mem_err_d = 1'b0;
        if (enter_done) begin
            mem_err_d = act_bad | act_both;
            if (!act_write) begin
                mem_din_d = act_bad ? 32'd0 : act_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            both_q    <= 1'b0;
            mem_din_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            both_q    <= both_d;
            mem_din_q <= mem_din_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign wr_en = (state_q == DONE) && write_q && !addr_bad(addr_q, ADDR_WIDTH) && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[addr_q[ADDR_WIDTH+1:2]] <= wdata_q;
        end
    end

`ifdef MEM_DEBUG_EN
    assign debug_data = mem_array[ADDR_WIDTH'(debug_addr)];
`endif

    assign mem_din   = mem_din_q;
    assign mem_err   = mem_err_q;
    assign mem_stall = (from_idle & req) | (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        ren   [2];
    logic        wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] dout  [2];
    logic [31:0] din   [2];
    logic        stall [2];
    logic        err   [2];
`ifdef MEM_DEBUG_EN
    logic [6:0]  dbg_addr [2];
    logic [31:0] dbg_data [2];
`endif

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_lat2 (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (ren[0]),
        .mem_wen   (wen[0]),
        .mem_addr  (addr[0]),
        .mem_dout  (dout[0]),
        .mem_din   (din[0]),
        .mem_stall (stall[0]),
        .mem_err   (err[0])
`ifdef MEM_DEBUG_EN
        ,
        .debug_addr (dbg_addr[0]),
        .debug_data (dbg_data[0])
`endif
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_lat0 (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (ren[1]),
        .mem_wen   (wen[1]),
        .mem_addr  (addr[1]),
        .mem_dout  (dout[1]),
        .mem_din   (din[1]),
        .mem_stall (stall[1]),
        .mem_err   (err[1])
`ifdef MEM_DEBUG_EN
        ,
        .debug_addr (dbg_addr[1]),
        .debug_data (dbg_data[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one access on instance d, holding the request until stall drops (DONE).
    task automatic applyStimulus(input int d, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rdata, output int stalls, output int errs);
        bit done;
        done   = 1'b0;
        stalls = 0;
        errs   = 0;
        rdata  = '0;
        @(negedge clk);
        ren[d]  = r;
        wen[d]  = w;
        addr[d] = a;
        dout[d] = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (err[d]) errs++;
            if (stall[d]) begin
                stalls++;
                @(negedge clk);
            end else begin
                done   = 1'b1;
                rdata  = din[d];
                ren[d] = 1'b0;
                wen[d] = 1'b0;
            end
        end
        if (!done) begin
            checkOutput("access_timeout", 32'd0, 32'd1);
            ren[d] = 1'b0;
            wen[d] = 1'b0;
        end
        @(negedge clk);
        #1;
        if (err[d]) errs++;
    endtask

    initial begin
        logic [31:0] rd;
        int          ns;
        int          ne;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ren[k]  = 1'b0;
            wen[k]  = 1'b0;
            addr[k] = '0;
            dout[k] = '0;
`ifdef MEM_DEBUG_EN
            dbg_addr[k] = '0;
`endif
        end
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_din",   din[0],   32'd0);
        checkOutput("reset_stall", {31'd0, stall[0]}, 32'd0);
        checkOutput("reset_err",   {31'd0, err[0]},   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LATENCY=2 write then read back
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, ns, ne);
        checkOutput("wr10_stalls", ns, 32'd3);
        checkOutput("wr10_err",    ne, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, rd, ns, ne);
        checkOutput("rd10_stalls", ns, 32'd3);
        checkOutput("rd10_data",   rd, 32'hDEADBEEF);
        checkOutput("rd10_err",    ne, 32'd0);

        // Error cases: misaligned and out-of-range
        applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'h11111111, rd, ns, ne);
        checkOutput("wr0_err", ne, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h12, 32'h0, rd, ns, ne);
        checkOutput("rd12_err",    ne, 32'd1);
        checkOutput("rd12_data",   rd, 32'd0);
        checkOutput("rd12_stalls", ns, 32'd3);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, rd, ns, ne);
        checkOutput("rd10_again", rd, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, rd, ns, ne);
        checkOutput("rd1000_err",  ne, 32'd1);
        checkOutput("rd1000_data", rd, 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'h00000BAD, rd, ns, ne);
        checkOutput("wr1000_err", ne, 32'd1);
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, rd, ns, ne);
        checkOutput("rd0_after_oor", rd, 32'h11111111);
        checkOutput("rd0_err",       ne, 32'd0);

        // Read and write together executes as a flagged write
        applyStimulus(0, 1'b1, 1'b1, 32'h8, 32'h55, rd, ns, ne);
        checkOutput("both_err", ne, 32'd1);
        applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0, rd, ns, ne);
        checkOutput("rd8_data", rd, 32'h55);

        // Abort mid-WAIT leaves word 8 and mem_din untouched
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h12345678, rd, ns, ne);
        @(negedge clk);
        wen[0] = 1'b1; addr[0] = 32'h20; dout[0] = 32'hAA;
        @(negedge clk);
        #1;
        checkOutput("abort_stall_wait", {31'd0, stall[0]}, 32'd1);
        wen[0] = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_stall_idle", {31'd0, stall[0]}, 32'd0);
        checkOutput("abort_err",        {31'd0, err[0]},   32'd0);
        checkOutput("abort_din_hold",   din[0], 32'h55);
        @(negedge clk);
        #1;
        checkOutput("abort_err_late", {31'd0, err[0]}, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, rd, ns, ne);
        checkOutput("abort_word8", rd, 32'h12345678);

        // Reset mid-WAIT discards the pending write
        @(negedge clk);
        wen[0] = 1'b1; addr[0] = 32'h20; dout[0] = 32'hAA;
        @(negedge clk);
        #1;
        checkOutput("rstwait_stall_before", {31'd0, stall[0]}, 32'd1);
        rst    = 1'b1;
        wen[0] = 1'b0;
        #1;
        checkOutput("rstwait_stall", {31'd0, stall[0]}, 32'd0);
        checkOutput("rstwait_din",   din[0], 32'd0);
        checkOutput("rstwait_err",   {31'd0, err[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, rd, ns, ne);
        checkOutput("rstwait_word8", rd, 32'h12345678);
        checkOutput("rstwait_rd_err", ne, 32'd0);

        // LATENCY=0: preload, then back-to-back reads
        applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'd1, rd, ns, ne);
        checkOutput("l0_wr0_stalls", ns, 32'd1);
        applyStimulus(1, 1'b0, 1'b1, 32'h4, 32'd2, rd, ns, ne);
        checkOutput("l0_wr4_stalls", ns, 32'd1);
        @(negedge clk);
        ren[1] = 1'b1; addr[1] = 32'h0;
        #1;
        checkOutput("l0_b2b_stall0", {31'd0, stall[1]}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("l0_b2b_done0",  {31'd0, stall[1]}, 32'd0);
        checkOutput("l0_b2b_data0",  din[1], 32'd1);
        addr[1] = 32'h4;
        @(negedge clk);
        #1;
        checkOutput("l0_b2b_stall1", {31'd0, stall[1]}, 32'd1);
        checkOutput("l0_b2b_hold",   din[1], 32'd1);
        @(negedge clk);
        #1;
        checkOutput("l0_b2b_done1",  {31'd0, stall[1]}, 32'd0);
        checkOutput("l0_b2b_data1",  din[1], 32'd2);
        checkOutput("l0_b2b_err",    {31'd0, err[1]}, 32'd0);
        ren[1] = 1'b0;

`ifdef MEM_DEBUG_EN
        applyStimulus(0, 1'b0, 1'b1, 32'h4, 32'h1234, rd, ns, ne);
        @(negedge clk);
        dbg_addr[0] = 7'd1;
        #1;
        checkOutput("dbg_data",  dbg_data[0], 32'h1234);
        checkOutput("dbg_stall", {31'd0, stall[0]}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
